gate_response_checker: RTL and testbench

- Receiving end of the gate-level stimulus/response flow: accepts observed {a, b, x} samples from a 2-input gate DUT over a valid/ready handshake.
- Compares each x against a programmable truth table, counts passes and failures, and captures the first failing vector.
- Sits beside the stimulus driver in self-checking benches and FPGA smoke tests, replacing manual $monitor inspection.

---
 rtl/gate_check_pkg.sv | 30 +++
 rtl/sat_counter.sv | 36 +++
 rtl/gate_response_checker.sv | 167 ++++++++++++++++
 tb/tb_gate_response_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
//   Shared types and constants for the gate response checker.
//   - state_t      : checker FSM states (IDLE, RUN, DONE), 2-bit encoding
//   - TT_*         : truth tables for common 2-input gates. Bit index is
//                    {a,b}, so TT[3] is the output for a=1, b=1.
//   - expected_bit : looks up the expected gate output for one input pair
// -----------------------------------------------------------------------------
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   // Expected gate output for inputs (a,b) under truth table tt.
   function automatic logic expected_bit(input logic [3:0] tt,
                                         input logic       a,
                                         input logic       b);
      return tt[{a, b}];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear that sticks at its maximum value
//   instead of wrapping.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset, counter -> 0
//     clr   : synchronous clear, counter -> 0 (wins over inc)
//     inc   : increment by one unless already at all-ones
//     count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//   Accepts observed {a,b,x} samples from a 2-input gate over a valid/ready
//   handshake, compares x against the truth table TT, counts matches and
//   mismatches, and records the first mismatching vector. A run is started
//   by a start pulse and ends after NUM_VEC accepted samples.
//
//   Parameters:
//     TT      : expected truth table, expected x = TT[{a,b}]
//     NUM_VEC : samples per run (1 .. 2**CNT_W-1)
//     CNT_W   : width of pass/fail counters
//
//   Ports:
//     clk, rst_n       : clock, synchronous active-low reset
//     start            : single-cycle pulse that begins a run
//     in_valid/in_ready: sample handshake, accept on in_valid & in_ready
//     in_a, in_b, in_x : observed gate inputs and output
//     busy             : run in progress
//     done             : run complete, held until the next start
//     pass             : done and no mismatches in the run
//     pass_cnt         : matching samples this run
//     fail_cnt         : mismatching samples this run
//     first_fail       : {a,b,x} of the first mismatch
//     first_fail_vld   : first_fail holds valid data
// -----------------------------------------------------------------------------
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] TT      = TT_AND,
   parameter int          NUM_VEC = 4,
   parameter int          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_x,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [2:0]       first_fail,
   output logic             first_fail_vld
);

   localparam int ACC_W = (NUM_VEC < 1) ? 1 : $clog2(NUM_VEC + 1);
   localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(NUM_VEC - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [ACC_W-1:0] acc_cnt_reg;
   logic [2:0]       first_fail_reg;
   logic             first_fail_vld_reg;

   logic             accept;
   logic             last_accept;
   logic             start_run;
   logic             mismatch;

   // Acceptance is derived from the registered state rather than in_ready
   // so the handshake and the next-state logic do not form a loop.
   assign accept      = in_valid && (state_reg == RUN);
   assign last_accept = accept && (acc_cnt_reg == LAST_IDX);

   // start is only honoured outside RUN; a start during a run is ignored.
   assign start_run   = start && (state_reg != RUN);

   // Case inequality so an X/Z on in_x is treated as a wrong answer.
   assign mismatch    = (in_x !== expected_bit(TT, in_a, in_b));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and Moore outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_accept) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Accepted-sample count and first-failure capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_cnt_reg        <= '0;
         first_fail_reg     <= 3'b000;
         first_fail_vld_reg <= 1'b0;
      end else if (start_run) begin
         acc_cnt_reg        <= '0;
         first_fail_reg     <= 3'b000;
         first_fail_vld_reg <= 1'b0;
      end else if (accept) begin
         acc_cnt_reg <= acc_cnt_reg + ACC_W'(1);
         if (mismatch && !first_fail_vld_reg) begin
            first_fail_reg     <= {in_a, in_b, in_x};
            first_fail_vld_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Pass / fail counters
   // ---------------------------------------------------------------------
   sat_counter #(
      .W (CNT_W)
   ) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_run),
      .inc   (accept && !mismatch),
      .count (pass_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_run),
      .inc   (accept && mismatch),
      .count (fail_cnt)
   );

   assign first_fail     = first_fail_reg;
   assign first_fail_vld = first_fail_vld_reg;
   assign pass           = done && (fail_cnt == '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
//   Directed bench for gate_response_checker. dut uses the default
//   AND / 4-vector / 8-bit configuration; dut2 uses AND / 3 vectors / 2-bit
//   counters. Inputs change 1 time unit after a rising edge and outputs are
//   sampled at the same point, i.e. after the edge that consumed them.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst_n;

   // Main instance signals
   logic       start, in_valid, in_a, in_b, in_x;
   logic       in_ready, busy, done, pass, first_fail_vld;
   logic [7:0] pass_cnt, fail_cnt;
   logic [2:0] first_fail;
   logic [4:0] flags;

   // Small-counter instance signals
   logic       start2, in_valid2, in_a2, in_b2, in_x2;
   logic       in_ready2, busy2, done2, pass2, first_fail_vld2;
   logic [1:0] pass_cnt2, fail_cnt2;
   logic [2:0] first_fail2;
   logic [4:0] flags2;

   int check_count = 0;
   int pass_count  = 0;

   always #5 clk = ~clk;

   assign flags  = {in_ready, busy, done, pass, first_fail_vld};
   assign flags2 = {in_ready2, busy2, done2, pass2, first_fail_vld2};

   gate_response_checker #(
      .TT      (4'b1000),
      .NUM_VEC (4),
      .CNT_W   (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .in_x           (in_x),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .pass_cnt       (pass_cnt),
      .fail_cnt       (fail_cnt),
      .first_fail     (first_fail),
      .first_fail_vld (first_fail_vld)
   );

   gate_response_checker #(
      .TT      (4'b1000),
      .NUM_VEC (3),
      .CNT_W   (2)
   ) dut2 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start2),
      .in_valid       (in_valid2),
      .in_ready       (in_ready2),
      .in_a           (in_a2),
      .in_b           (in_b2),
      .in_x           (in_x2),
      .busy           (busy2),
      .done           (done2),
      .pass           (pass2),
      .pass_cnt       (pass_cnt2),
      .fail_cnt       (fail_cnt2),
      .first_fail     (first_fail2),
      .first_fail_vld (first_fail_vld2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one sample with in_valid high for one edge.
   task automatic send(input logic [2:0] s);
      {in_a, in_b, in_x} = s;
      in_valid = 1'b1;
      step();
      $display("dut  sample a=%b b=%b x=%b pass_cnt=%0d fail_cnt=%0d", s[2], s[1], s[0], pass_cnt, fail_cnt);
   endtask

   task automatic send2(input logic [2:0] s);
      {in_a2, in_b2, in_x2} = s;
      in_valid2 = 1'b1;
      step();
      $display("dut2 sample a=%b b=%b x=%b pass_cnt=%0d fail_cnt=%0d", s[2], s[1], s[0], pass_cnt2, fail_cnt2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      check_count++;
      if (flags !== 5'b00000) $display("FAIL reset_flags: got %b want 00000", flags);
      else pass_count++;
      check_count++;
      if ({pass_cnt, fail_cnt, first_fail} !== 19'd0)
         $display("FAIL reset_counts: got pass=%0d fail=%0d ff=%b want 0 0 000", pass_cnt, fail_cnt, first_fail);
      else pass_count++;
      rst_n = 1'b1;
      step();
      check_count++;
      if (flags !== 5'b00000) $display("FAIL reset_idle_flags: got %b want 00000", flags);
      else pass_count++;
   endtask

   task automatic test_all_pass();
      pulse_start();
      check_count++;
      if (flags !== 5'b11000) $display("FAIL all_pass_run_flags: got %b want 11000", flags);
      else pass_count++;
      send(3'b000);
      send(3'b010);
      start = 1'b1;             // start during RUN must be ignored
      send(3'b100);
      start = 1'b0;
      send(3'b111);
      check_count++;
      if (flags !== 5'b00110) $display("FAIL all_pass_done_flags: got %b want 00110", flags);
      else pass_count++;
      check_count++;
      if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0)
         $display("FAIL all_pass_counts: got pass=%0d fail=%0d want 4 0", pass_cnt, fail_cnt);
      else pass_count++;
      // in_valid still high: a fifth sample must not be taken.
      {in_a, in_b, in_x} = 3'b110;
      step();
      in_valid = 1'b0;
      check_count++;
      if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0 || done !== 1'b1)
         $display("FAIL back_to_back_extra: got pass=%0d fail=%0d done=%b want 4 0 1", pass_cnt, fail_cnt, done);
      else pass_count++;
   endtask

   task automatic test_fail();
      pulse_start();
      check_count++;
      if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0)
         $display("FAIL fail_start_clear: got pass=%0d fail=%0d want 0 0", pass_cnt, fail_cnt);
      else pass_count++;
      send(3'b000);
      send(3'b011);
      send(3'b100);
      send(3'b110);
      in_valid = 1'b0;
      check_count++;
      if (flags !== 5'b00101) $display("FAIL fail_flags: got %b want 00101", flags);
      else pass_count++;
      check_count++;
      if (pass_cnt !== 8'd2 || fail_cnt !== 8'd2)
         $display("FAIL fail_counts: got pass=%0d fail=%0d want 2 2", pass_cnt, fail_cnt);
      else pass_count++;
      check_count++;
      if (first_fail !== 3'b011) $display("FAIL fail_first_fail: got %b want 011", first_fail);
      else pass_count++;
   endtask

   // Continues from the DONE state left by test_fail.
   task automatic test_done_hold();
      {in_a, in_b, in_x} = 3'b011;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_count++;
         if (pass_cnt !== 8'd2 || fail_cnt !== 8'd2 || flags !== 5'b00101)
            $display("FAIL done_hold_%0d: got pass=%0d fail=%0d flags=%b want 2 2 00101", i, pass_cnt, fail_cnt, flags);
         else pass_count++;
      end
      in_valid = 1'b0;
      pulse_start();
      check_count++;
      if (flags !== 5'b11000 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || first_fail !== 3'b000)
         $display("FAIL restart_clear: got flags=%b pass=%0d fail=%0d ff=%b want 11000 0 0 000", flags, pass_cnt, fail_cnt, first_fail);
      else pass_count++;
      send(3'b000);
      send(3'b010);
      send(3'b100);
      send(3'b111);
      in_valid = 1'b0;
      check_count++;
      if (flags !== 5'b00110 || pass_cnt !== 8'd4 || fail_cnt !== 8'd0)
         $display("FAIL restart_run: got flags=%b pass=%0d fail=%0d want 00110 4 0", flags, pass_cnt, fail_cnt);
      else pass_count++;
   endtask

   task automatic test_gaps();
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int acc = 0;
      logic exp_done;
      pulse_start();
      {in_a, in_b, in_x} = 3'b111;
      for (int i = 0; i < 7; i++) begin
         in_valid = (pat[i] != 0);
         step();
         if (pat[i] != 0) acc++;
         exp_done = (acc == 4);
         $display("dut  gap cycle %0d valid=%0d accepted=%0d", i, pat[i], pass_cnt);
         check_count++;
         if (done !== exp_done || busy !== !exp_done || pass_cnt !== 8'(acc))
            $display("FAIL gaps_cycle_%0d: got done=%b busy=%b pass=%0d want %b %b %0d",
                     i, done, busy, pass_cnt, exp_done, !exp_done, acc);
         else pass_count++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midrun();
      pulse_start();
      send(3'b001);
      send(3'b010);
      in_valid = 1'b0;
      rst_n = 1'b0;
      start = 1'b1;             // reset must win over start
      step();
      check_count++;
      if (flags !== 5'b00000 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || first_fail !== 3'b000)
         $display("FAIL midrun_reset: got flags=%b pass=%0d fail=%0d ff=%b want 00000 0 0 000", flags, pass_cnt, fail_cnt, first_fail);
      else pass_count++;
      rst_n = 1'b1;
      start = 1'b0;
      step();
      check_count++;
      if (flags !== 5'b00000) $display("FAIL reset_beats_start: got %b want 00000", flags);
      else pass_count++;
      pulse_start();
      send(3'b110);
      send(3'b000);
      send(3'b010);
      send(3'b100);
      in_valid = 1'b0;
      check_count++;
      if (flags !== 5'b00101 || pass_cnt !== 8'd3 || fail_cnt !== 8'd1 || first_fail !== 3'b110)
         $display("FAIL post_reset_run: got flags=%b pass=%0d fail=%0d ff=%b want 00101 3 1 110", flags, pass_cnt, fail_cnt, first_fail);
      else pass_count++;
   endtask

   task automatic test_small_counters();
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      send2(3'b001);
      send2(3'b011);
      send2(3'b101);
      in_valid2 = 1'b0;
      check_count++;
      if (fail_cnt2 !== 2'd3 || pass_cnt2 !== 2'd0 || flags2 !== 5'b00101 || first_fail2 !== 3'b001)
         $display("FAIL small_all_fail: got fail=%0d pass=%0d flags=%b ff=%b want 3 0 00101 001", fail_cnt2, pass_cnt2, flags2, first_fail2);
      else pass_count++;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      send2(3'b000);
      send2(3'b010);
      send2(3'b111);
      in_valid2 = 1'b0;
      check_count++;
      if (pass_cnt2 !== 2'd3 || fail_cnt2 !== 2'd0 || flags2 !== 5'b00110)
         $display("FAIL small_all_pass: got pass=%0d fail=%0d flags=%b want 3 0 00110", pass_cnt2, fail_cnt2, flags2);
      else pass_count++;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;  in_valid = 1'b0;  in_a = 1'b0;  in_b = 1'b0;  in_x = 1'b0;
      start2 = 1'b0; in_valid2 = 1'b0; in_a2 = 1'b0; in_b2 = 1'b0; in_x2 = 1'b0;
      test_reset();
      test_all_pass();
      test_fail();
      test_done_hold();
      test_gaps();
      test_reset_midrun();
      test_small_counters();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
